// File: rtl/lane_merge_l2_if.sv
// Handshake bundle between the L1 mux stage, the two-lane merger and the downstream consumer.
interface lane_merge_l2_if;
    logic [7:0] dataIn0;
    logic       validIn0;
    logic [7:0] dataIn1;
    logic       validIn1;
    logic       outReady;
    logic [7:0] dataOut;
    logic       validOut;
    logic       overflow0;
    logic       overflow1;
    logic       empty;

    modport slave (
        input  dataIn0, validIn0, dataIn1, validIn1, outReady,
        output dataOut, validOut, overflow0, overflow1, empty
    );

    modport master (
        output dataIn0, validIn0, dataIn1, validIn1, outReady,
        input  dataOut, validOut, overflow0, overflow1, empty
    );
endinterface

// File: rtl/lane_merge_l2.sv
// Merges two byte lanes into one stream by strict lane0/lane1 alternation,
// each lane buffered by a DEPTH-entry FIFO, with sticky per-lane overflow flags.
module lane_merge_l2 #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lane_merge_l2_if.slave       bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [2][DEPTH];
    logic [AW-1:0] wp_r [2];
    logic [AW-1:0] rp_r [2];
    logic [CW-1:0] cnt_r [2];
    logic [1:0]    ovf_r;
    logic          sel_r;
    logic [7:0]    data_out_r;
    logic          valid_out_r;

    logic [7:0]    din_s [2];
    logic [1:0]    vin_s;
    logic          load_s;
    logic [1:0]    pop_s;
    logic [1:0]    wr_s;
    logic [1:0]    drop_s;
    logic [7:0]    head_s;

    // Per-lane write/pop/drop decisions for the coming edge
    always_comb begin
        din_s[0] = bus.dataIn0;
        din_s[1] = bus.dataIn1;
        vin_s    = {bus.validIn1, bus.validIn0};
        load_s   = !valid_out_r || bus.outReady;
        pop_s[0] = load_s && !sel_r && (cnt_r[0] != {CW{1'b0}});
        pop_s[1] = load_s &&  sel_r && (cnt_r[1] != {CW{1'b0}});
        // A full lane may still accept a byte when it is popped at the same edge
        for (int l = 0; l < 2; l++) begin
            wr_s[l]   = vin_s[l] && ((cnt_r[l] != CW'(DEPTH)) || pop_s[l]);
            drop_s[l] = vin_s[l] && !wr_s[l];
        end
        if (sel_r) begin
            head_s = mem_r[1][rp_r[1]];
        end else begin
            head_s = mem_r[0][rp_r[0]];
        end
    end

    // FIFO storage; contents are don't-care after reset so no clear is needed
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!reset && wr_s[l]) begin
                mem_r[l][wp_r[l]] <= din_s[l];
            end
        end
    end

    // Pointers, counts, overflow flags, turn pointer and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                wp_r[l]  <= {AW{1'b0}};
                rp_r[l]  <= {AW{1'b0}};
                cnt_r[l] <= {CW{1'b0}};
            end
            ovf_r       <= 2'b00;
            sel_r       <= 1'b0;
            data_out_r  <= 8'h00;
            valid_out_r <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (wr_s[l]) begin
                    wp_r[l] <= wp_r[l] + AW'(1);
                end
                if (pop_s[l]) begin
                    rp_r[l] <= rp_r[l] + AW'(1);
                end
                if (wr_s[l] && !pop_s[l]) begin
                    cnt_r[l] <= cnt_r[l] + CW'(1);
                end else if (pop_s[l] && !wr_s[l]) begin
                    cnt_r[l] <= cnt_r[l] - CW'(1);
                end
                if (drop_s[l]) begin
                    ovf_r[l] <= 1'b1;
                end
            end
            // Only the lane whose turn it is may be popped; otherwise the slot goes idle
            if (load_s) begin
                if (|pop_s) begin
                    data_out_r  <= head_s;
                    valid_out_r <= 1'b1;
                    sel_r       <= ~sel_r;
                end else begin
                    valid_out_r <= 1'b0;
                end
            end
        end
    end

    assign bus.dataOut   = data_out_r;
    assign bus.validOut  = valid_out_r;
    assign bus.overflow0 = ovf_r[0];
    assign bus.overflow1 = ovf_r[1];
    assign bus.empty     = (cnt_r[0] == {CW{1'b0}}) && (cnt_r[1] == {CW{1'b0}}) && !valid_out_r;

endmodule
